nec_ir_tx: RTL and testbench

NEC-protocol infrared transmitter: accepts an 8-bit address and 8-bit command and emits a complete NEC frame on one pin. It can also emit an NEC repeat code instead of a frame. Its output is either the raw mark/space envelope or that envelope gated by a 38 kHz carrier. It is the transmit-side counterpart of the IR decoder in the music-player system: used for board-to-board remote control and for closed-loop self-test of the decoder, with `env_o` wired to the decoder's `iIR` input.

---
 rtl/nec_ir_tx.sv | 164 ++++++++++++++++
 tb/tb_nec_ir_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: sends a 32-bit address/command frame or a repeat code on env_o/ir_o.
// Define NEC_TX_CARRIER_EN to gate ir_o with a 38 kHz carrier; otherwise ir_o mirrors env_o.
module nec_ir_tx #(
  parameter int unsigned TICK_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned GAP_UNITS    = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       repeat_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] cmd_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       env_o,
  output logic       ir_o
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);
  // Five bits cover every protocol duration; widen only when the gap needs more.
  localparam int unsigned UW = ($clog2(GAP_UNITS) > 5) ? $clog2(GAP_UNITS) : 5;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [UW-1:0] unit_q, unit_d, unit_last;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   sr_q, sr_d;
  logic          rep_q, rep_d;
  logic          busy_q, busy_d, done_q, done_d, env_q, env_d, ir_q, ir_d;
  logic          unit_tick, state_end;

`ifdef NEC_TX_CARRIER_EN
  localparam int unsigned CCW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CCW-1:0] CAR_LAST = CCW'(CARRIER_HALF - 1);
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic           car_q, car_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    unit_last = '0;
    case (state_q)
      S_LEAD_MARK:  unit_last = UW'(15);
      S_LEAD_SPACE: unit_last = rep_q ? UW'(3) : UW'(7);
      S_BIT_SPACE:  unit_last = sr_q[0] ? UW'(2) : UW'(0);
      S_GAP:        unit_last = UW'(GAP_UNITS - 1);
      default:      unit_last = '0;
    endcase
    unit_tick = (cyc_q == TICK_LAST);
    state_end = unit_tick && (unit_q == unit_last);

    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rep_d   = rep_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      cyc_d  = '0;
      unit_d = '0;
      if (start_i) begin
        state_d = S_LEAD_MARK;
        sr_d    = {~cmd_i, cmd_i, ~addr_i, addr_i};
        rep_d   = repeat_i;
        bit_d   = '0;
      end
    end else if (state_end) begin
      cyc_d  = '0;
      unit_d = '0;
      case (state_q)
        S_LEAD_MARK:  state_d = S_LEAD_SPACE;
        S_LEAD_SPACE: state_d = rep_q ? S_STOP_MARK : S_BIT_MARK;
        S_BIT_MARK:   state_d = S_BIT_SPACE;
        S_BIT_SPACE: begin
          sr_d    = {1'b0, sr_q[31:1]};
          bit_d   = bit_q + 6'd1;
          state_d = (bit_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
        S_STOP_MARK:  state_d = S_GAP;
        S_GAP: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default:      state_d = S_IDLE;
      endcase
    end else if (unit_tick) begin
      cyc_d  = '0;
      unit_d = unit_q + UW'(1);
    end else begin
      cyc_d = cyc_q + CW'(1);
    end

    busy_d = (state_d != S_IDLE);
    env_d  = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) || (state_d == S_STOP_MARK);

`ifdef NEC_TX_CARRIER_EN
    // Each mark restarts the carrier so it always opens with a high half-period.
    ccnt_d = '0;
    car_d  = 1'b0;
    if (env_d && !env_q) begin
      car_d = 1'b1;
    end else if (env_d) begin
      if (ccnt_q == CAR_LAST) begin
        car_d = ~car_q;
      end else begin
        ccnt_d = ccnt_q + CCW'(1);
        car_d  = car_q;
      end
    end
    ir_d = env_d & car_d;
`else
    ir_d = env_d;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      ir_q    <= 1'b0;
`ifdef NEC_TX_CARRIER_EN
      ccnt_q  <= '0;
      car_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      env_q   <= env_d;
      ir_q    <= ir_d;
`ifdef NEC_TX_CARRIER_EN
      ccnt_q  <= ccnt_d;
      car_q   <= car_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign env_o  = env_q;
  assign ir_o   = ir_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboarded bench for nec_ir_tx: expected envelope segments, done latencies and decoded
// words are queued at each request and compared as the monitor observes the DUT.
module tb_nec_ir_tx;

  localparam int T  = 4;
  localparam int CH = 2;
  localparam int G  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_i = 1'b0;
  logic       repeat_i = 1'b0;
  logic [7:0] addr_i = 8'h00;
  logic [7:0] cmd_i = 8'h00;
  logic       busy_o, done_o, env_o, ir_o;

  nec_ir_tx #(.TICK_CYCLES(T), .CARRIER_HALF(CH), .GAP_UNITS(G)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .repeat_i(repeat_i),
    .addr_i(addr_i), .cmd_i(cmd_i), .busy_o(busy_o), .done_o(done_o),
    .env_o(env_o), .ir_o(ir_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit lvl; int len; } seg_t;
  seg_t        exp_seg[$];
  int          exp_lat[$];
  logic [31:0] exp_word[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void add_seg(input bit lvl, input int len);
    seg_t s;
    s.lvl = lvl;
    s.len = len;
    exp_seg.push_back(s);
  endfunction

  // Protocol-level model of one transmission.
  function automatic void push_tx(input logic [7:0] a, input logic [7:0] c, input bit rep);
    logic [31:0] w;
    add_seg(1'b1, 16 * T);
    if (rep) begin
      add_seg(1'b0, 4 * T);
      exp_lat.push_back((21 + G) * T + 1);
    end else begin
      add_seg(1'b0, 8 * T);
      w = {~c, c, ~a, a};
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, T);
        add_seg(1'b0, w[i] ? 3 * T : T);
      end
      exp_word.push_back(w);
      exp_lat.push_back((121 + G) * T + 1);
    end
    add_seg(1'b1, T);
    add_seg(1'b0, G * T);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: envelope run lengths while busy, bench-side NEC decoder, done latency, ir_o.
  bit          run_active = 1'b0;
  bit          run_lvl = 1'b0;
  int          run_len = 0;
  bit          prev_busy = 1'b0;
  int          rise_cyc = 0;
  int          bitcnt = 0;
  logic [31:0] word = '0;

  task automatic close_run();
    seg_t        s;
    logic [31:0] w;
    if (abort) return;
    if (exp_seg.size() == 0) begin
      check("extra_seg", 32'(run_len), 32'd0);
    end else begin
      s = exp_seg.pop_front();
      check("seg_lvl", {31'd0, run_lvl}, {31'd0, s.lvl});
      check("seg_len", 32'(run_len), 32'(s.len));
    end
    if (!run_lvl) begin
      if (run_len == 8 * T) begin
        bitcnt = 0;
      end else if (run_len == T || run_len == 3 * T) begin
        if (bitcnt < 32) word[bitcnt] = (run_len == 3 * T);
        bitcnt++;
      end else if (run_len == G * T) begin
        if (bitcnt == 32) begin
          if (exp_word.size() == 0) begin
            check("extra_word", word, 32'd0);
          end else begin
            w = exp_word.pop_front();
            check("dec_addr", {24'd0, word[7:0]}, {24'd0, w[7:0]});
            check("dec_naddr", {24'd0, word[15:8]}, {24'd0, w[15:8]});
            check("dec_cmd", {24'd0, word[23:16]}, {24'd0, w[23:16]});
            check("dec_ncmd", {24'd0, word[31:24]}, {24'd0, w[31:24]});
          end
        end
        bitcnt = 0;
      end
    end
  endtask

  initial forever begin
    bit exp_ir;
    @(negedge clk);
    if (run_active && busy_o && env_o == run_lvl) begin
      run_len++;
    end else begin
      if (run_active) close_run();
      run_active = busy_o;
      run_lvl    = env_o;
      run_len    = 1;
    end
`ifdef NEC_TX_CARRIER_EN
    exp_ir = (busy_o && env_o) ? (((run_len - 1) / CH) % 2 == 0) : 1'b0;
`else
    exp_ir = env_o;
`endif
    check("ir_o", {31'd0, ir_o}, {31'd0, exp_ir});
    if (busy_o && !prev_busy) rise_cyc = cyc;
    if (done_o) begin
      if (exp_lat.size() == 0) check("extra_done", 32'd1, 32'd0);
      else check("done_lat", 32'(cyc - rise_cyc + 1), 32'(exp_lat.pop_front()));
    end
    prev_busy = busy_o;
    if (abort && !busy_o) begin
      exp_seg.delete();
      exp_lat.delete();
      exp_word.delete();
      bitcnt     = 0;
      run_active = 1'b0;
      abort      = 1'b0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] c, input bit rep);
    @(posedge clk);
    #1;
    addr_i = a; cmd_i = c; repeat_i = rep; start_i = 1'b1;
    push_tx(a, c, rep);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    addr_i = 8'($urandom); cmd_i = 8'($urandom); repeat_i = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done_o) break;
      n++;
    end
    if (n >= budget) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_env", {31'd0, env_o}, 32'd0);
    check("rst_ir", {31'd0, ir_o}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    send(8'h00, 8'hFF, 1'b0);
    wait_done(700);
    send(8'hAB, 8'hCD, 1'b1);
    wait_done(200);
    send(8'h5A, 8'h3C, 1'b0);
    wait_done(700);

    // A start pulse mid-frame must be ignored.
    send(8'h12, 8'h34, 1'b0);
    repeat (100) @(posedge clk);
    #1 start_i = 1'b1; addr_i = 8'hEE;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(700);

    // start_i held high gives back-to-back frames.
    @(posedge clk);
    #1 addr_i = 8'h81; cmd_i = 8'h7E; repeat_i = 1'b0; start_i = 1'b1;
    push_tx(8'h81, 8'h7E, 1'b0);
    push_tx(8'h81, 8'h7E, 1'b0);
    wait_done(700);
    @(negedge clk);
    check("b2b_lead_env", {31'd0, env_o}, 32'd1);
    check("b2b_lead_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(700);

    // One-cycle reset during bit 10 aborts without done.
    send(8'h00, 8'h00, 1'b0);
    repeat (194) @(posedge clk);
    #1 reset_n = 1'b0; abort = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_env", {31'd0, env_o}, 32'd0);
    check("abort_ir", {31'd0, ir_o}, 32'd0);
    repeat (30) @(posedge clk);
    send(8'hC3, 8'h81, 1'b0);
    wait_done(700);

    repeat (5) @(posedge clk);
    check("seg_left", 32'(exp_seg.size()), 32'd0);
    check("lat_left", 32'(exp_lat.size()), 32'd0);
    check("word_left", 32'(exp_word.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
